counter_sequencer: RTL and testbench

- Control FSM that sequences the 8-bit up/down counter datapath.
- Debounces two raw pushbuttons: run/pause and direction.
- Gates the clkEnable tick into the counter enable and drives the counter's up_down and clear inputs.
- Optionally auto-reverses direction at programmable limits. Sits between clkEnable/keys and updown_counter in top.

---
 rtl/counter_sequencer_pkg.sv | 23 ++
 rtl/counter_sequencer_if.sv | 24 ++
 rtl/counter_sequencer_key_debounce.sv | 53 +++++
 rtl/counter_sequencer.sv | 91 +++++++++
 tb/tb_counter_sequencer.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/counter_sequencer_pkg.sv
// Shared definitions for the counter sequencer: FSM states, direction
// encodings, default debounce length and a counter sizing helper.
package counter_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_CLEAR = 2'b11
  } seq_state_t;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // 10 ms at 5 MHz
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 50000;

  // Bits needed to hold values 0..n inclusive (at least one bit).
  function automatic int unsigned cnt_bits(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/counter_sequencer_if.sv
// Keys, tick and counter handshake between the sequencer and its neighbours.
interface counter_sequencer_if #(
  parameter int WIDTH = 8
);
  logic             tick;
  logic             key_run;
  logic             key_dir;
  logic [WIDTH-1:0] count_in;
  logic             up_down;
  logic             cnt_enable;
  logic             cnt_clear;
  logic             limit_hit;
  logic [1:0]       state_out;

  modport master (
    output tick, key_run, key_dir, count_in,
    input  up_down, cnt_enable, cnt_clear, limit_hit, state_out
  );

  modport slave (
    input  tick, key_run, key_dir, count_in,
    output up_down, cnt_enable, cnt_clear, limit_hit, state_out
  );
endinterface

// File: rtl/counter_sequencer_key_debounce.sv
// Pushbutton debouncer: 2-FF synchronizer, stability counter and a
// one-cycle pulse on the released->pressed transition (key is active-low).
module key_debounce
  import counter_sequencer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clock_5,
  input  logic reset,
  input  logic key,
  output logic press
);

  localparam int unsigned     CW      = cnt_bits(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   CNT_MAX = CW'(DEBOUNCE_CYCLES);

  logic          sync_1;
  logic          sync_2;
  logic          level;
  logic [CW-1:0] stable_cnt;

  // Bring the asynchronous key into the clock domain; released level is 1.
  always_ff @(posedge clock_5) begin
    if (!reset) begin
      sync_1 <= 1'b1;
      sync_2 <= 1'b1;
    end else begin
      sync_1 <= key;
      sync_2 <= sync_1;
    end
  end

  // Count cycles the synced level disagrees with the debounced level; adopt it once long enough.
  always_ff @(posedge clock_5) begin
    if (!reset) begin
      level      <= 1'b1;
      stable_cnt <= '0;
      press      <= 1'b0;
    end else begin
      press <= 1'b0;
      if (sync_2 == level) begin
        stable_cnt <= '0;
      end else if (stable_cnt == CNT_MAX) begin
        level      <= sync_2;
        stable_cnt <= '0;
        press      <= ~sync_2;
      end else begin
        stable_cnt <= stable_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/counter_sequencer.sv
// Control FSM for the up/down counter: debounced run/pause and direction
// keys, tick gating into the counter enable, and limit auto-reversal.
module counter_sequencer
  import counter_sequencer_pkg::*;
#(
  parameter int               WIDTH           = 8,
  parameter int unsigned      DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter logic [WIDTH-1:0] UPPER_LIMIT     = '1,
  parameter logic [WIDTH-1:0] LOWER_LIMIT     = '0,
  parameter bit               AUTO_REVERSE    = 1'b1
) (
  input logic                clock_5,
  input logic                reset,
  counter_sequencer_if.slave bus
);

  seq_state_t state;
  logic       dir;
  logic       clear_q;
  logic       limit_q;
  logic       run_press;
  logic       dir_press;
  logic       run_tick;
  logic       at_limit;
  logic       suppress;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run_key (
    .clock_5 (clock_5),
    .reset   (reset),
    .key     (bus.key_run),
    .press   (run_press)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dir_key (
    .clock_5 (clock_5),
    .reset   (reset),
    .key     (bus.key_dir),
    .press   (dir_press)
  );

  // Limit detection and step enable, all from the pre-edge state.
  always_comb begin
    run_tick = bus.tick & (state == ST_RUN);
    at_limit = 1'b0;
    if (run_tick) begin
      at_limit = ((dir == DIR_UP)   && (bus.count_in == UPPER_LIMIT)) ||
                 ((dir == DIR_DOWN) && (bus.count_in == LOWER_LIMIT));
    end
    suppress       = AUTO_REVERSE & at_limit;
    bus.cnt_enable = run_tick & ~suppress;
  end

  // Sequencer state, direction and the registered clear/limit pulses.
  always_ff @(posedge clock_5) begin
    if (!reset) begin
      state   <= ST_IDLE;
      dir     <= DIR_UP;
      clear_q <= 1'b0;
      limit_q <= 1'b0;
    end else begin
      clear_q <= 1'b0;
      limit_q <= at_limit;
      if (state == ST_CLEAR) begin
        state <= ST_IDLE;
        dir   <= DIR_UP;
      end else if (run_press && dir_press) begin
        state   <= ST_CLEAR;
        clear_q <= 1'b1;
      end else begin
        if (run_press) begin
          case (state)
            ST_IDLE:  state <= ST_RUN;
            ST_RUN:   state <= ST_PAUSE;
            ST_PAUSE: state <= ST_RUN;
            default:  state <= ST_IDLE;
          endcase
        end
        // A dir press coinciding with an auto-reversal still inverts only once.
        if (dir_press || suppress) begin
          dir <= ~dir;
        end
      end
    end
  end

  assign bus.up_down   = dir;
  assign bus.cnt_clear = clear_q;
  assign bus.limit_hit = limit_q;
  assign bus.state_out = state;

endmodule

// File: tb/tb_counter_sequencer.sv
// Randomized bench for counter_sequencer: two instances (auto-reverse on and
// off) share keys/tick/reset, each feeds a behavioural up/down counter, and
// every cycle is compared with a reference model of the sequencer rules.
module tb_counter_sequencer;
  import counter_sequencer_pkg::*;

  localparam int unsigned DC = 4;
  localparam logic [7:0]  UL = 8'h05;
  localparam logic [7:0]  LL = 8'h00;

  logic clock_5 = 1'b0;
  logic reset   = 1'b0;
  always #5 clock_5 = ~clock_5;

  counter_sequencer_if #(.WIDTH(8)) bus_ar ();
  counter_sequencer_if #(.WIDTH(8)) bus_wr ();

  counter_sequencer #(
    .WIDTH(8), .DEBOUNCE_CYCLES(DC), .UPPER_LIMIT(UL), .LOWER_LIMIT(LL), .AUTO_REVERSE(1'b1)
  ) dut_ar (
    .clock_5 (clock_5),
    .reset   (reset),
    .bus     (bus_ar)
  );

  counter_sequencer #(
    .WIDTH(8), .DEBOUNCE_CYCLES(DC), .UPPER_LIMIT(UL), .LOWER_LIMIT(LL), .AUTO_REVERSE(1'b0)
  ) dut_wr (
    .clock_5 (clock_5),
    .reset   (reset),
    .bus     (bus_wr)
  );

  // The datapath counters driven by the DUT outputs.
  logic [7:0] cnt_ar, cnt_wr;
  always_ff @(posedge clock_5) begin
    if (!reset) begin
      cnt_ar <= '0;
      cnt_wr <= '0;
    end else begin
      if (bus_ar.cnt_clear)       cnt_ar <= '0;
      else if (bus_ar.cnt_enable) cnt_ar <= bus_ar.up_down ? cnt_ar + 8'd1 : cnt_ar - 8'd1;
      if (bus_wr.cnt_clear)       cnt_wr <= '0;
      else if (bus_wr.cnt_enable) cnt_wr <= bus_wr.up_down ? cnt_wr + 8'd1 : cnt_wr - 8'd1;
    end
  end
  assign bus_ar.count_in = cnt_ar;
  assign bus_wr.count_in = cnt_wr;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check_val(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Stimulus state
  logic        key_run_v = 1'b1;
  logic        key_dir_v = 1'b1;
  logic        tick_v    = 1'b0;
  int unsigned rst_hold  = 3;
  bit          arm_rst_clear = 1'b0;
  int unsigned cyc = 0;

  // Reference model. States: 0 idle, 1 run, 2 pause, 3 clear.
  // Instance 0 auto-reverses, instance 1 wraps.
  int unsigned m_st [2];
  logic        m_dir[2];
  logic        m_clr[2];
  logic        m_lim[2];
  logic [7:0]  m_cnt[2];
  // Key history: bit 0 is the newest raw sample; a press is seen two samples
  // late and needs DC+1 consecutive samples opposite to the current level.
  logic [DC+2:0] h_run, h_dir;
  logic          lvl_run, lvl_dir;
  logic          p_run, p_dir;
  string         nm[2] = '{"ar", "wr"};

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_st[m] = 0; m_dir[m] = 1'b1; m_clr[m] = 1'b0; m_lim[m] = 1'b0; m_cnt[m] = '0;
    end
    h_run = '1; h_dir = '1; lvl_run = 1'b1; lvl_dir = 1'b1; p_run = 1'b0; p_dir = 1'b0;
  endtask

  function automatic logic exp_limit(input int m);
    if (!(tick_v && m_st[m] == 1)) return 1'b0;
    return (m_dir[m] && m_cnt[m] == UL) || (!m_dir[m] && m_cnt[m] == LL);
  endfunction

  function automatic logic exp_enable(input int m);
    return tick_v && m_st[m] == 1 && !(m == 0 && exp_limit(m));
  endfunction

  task automatic deb_step(inout logic [DC+2:0] h, inout logic lvl, input logic raw, output logic p);
    h = {h[DC+1:0], raw};
    p = 1'b0;
    if (h[DC+2:2] == {(DC+1){~lvl}}) begin
      lvl = ~lvl;
      p   = ~lvl;
    end
  endtask

  task automatic model_edge();
    logic lim, rev, en;
    if (!reset) begin
      model_reset();
      return;
    end
    for (int m = 0; m < 2; m++) begin
      lim = exp_limit(m);
      rev = lim && (m == 0);
      en  = exp_enable(m);
      if (m_clr[m])  m_cnt[m] = '0;
      else if (en)   m_cnt[m] = m_dir[m] ? m_cnt[m] + 8'd1 : m_cnt[m] - 8'd1;
      m_lim[m] = lim;
      m_clr[m] = 1'b0;
      if (m_st[m] == 3) begin
        m_st[m]  = 0;
        m_dir[m] = 1'b1;
      end else if (p_run && p_dir) begin
        m_st[m]  = 3;
        m_clr[m] = 1'b1;
      end else begin
        if (p_run) m_st[m] = (m_st[m] == 1) ? 2 : 1;
        if (p_dir || rev) m_dir[m] = ~m_dir[m];
      end
    end
    deb_step(h_run, lvl_run, key_run_v, p_run);
    deb_step(h_dir, lvl_dir, key_dir_v, p_dir);
  endtask

  task automatic check_outputs();
    check_val("ar.state",      bus_ar.state_out,  m_st[0]);
    check_val("ar.up_down",    bus_ar.up_down,    m_dir[0]);
    check_val("ar.cnt_enable", bus_ar.cnt_enable, exp_enable(0));
    check_val("ar.cnt_clear",  bus_ar.cnt_clear,  m_clr[0]);
    check_val("ar.limit_hit",  bus_ar.limit_hit,  m_lim[0]);
    check_val("ar.count",      cnt_ar,            m_cnt[0]);
    check_val("wr.state",      bus_wr.state_out,  m_st[1]);
    check_val("wr.up_down",    bus_wr.up_down,    m_dir[1]);
    check_val("wr.cnt_enable", bus_wr.cnt_enable, exp_enable(1));
    check_val("wr.cnt_clear",  bus_wr.cnt_clear,  m_clr[1]);
    check_val("wr.limit_hit",  bus_wr.limit_hit,  m_lim[1]);
    check_val("wr.count",      cnt_wr,            m_cnt[1]);
  endtask

  // One clock: drive inputs after the falling edge, check, then advance the model.
  task automatic step_cycle();
    @(negedge clock_5);
    if (arm_rst_clear && m_st[0] == 3) begin
      rst_hold      = 1;
      arm_rst_clear = 1'b0;
    end
    if (rst_hold > 0) begin
      reset = 1'b0;
      rst_hold--;
    end else begin
      reset = 1'b1;
    end
    tick_v = (cyc % 3 == 0);
    bus_ar.tick = tick_v;      bus_wr.tick = tick_v;
    bus_ar.key_run = key_run_v; bus_wr.key_run = key_run_v;
    bus_ar.key_dir = key_dir_v; bus_wr.key_dir = key_dir_v;
    #1;
    check_outputs();
    model_edge();
    cyc++;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step_cycle();
  endtask

  task automatic press(input bit run, input bit dr, input int unsigned hold, input int unsigned gap);
    key_run_v = ~run;
    key_dir_v = ~dr;
    idle(hold);
    key_run_v = 1'b1;
    key_dir_v = 1'b1;
    idle(gap);
  endtask

  initial begin
    int unsigned r;
    bus_ar.tick = 1'b0; bus_wr.tick = 1'b0;
    bus_ar.key_run = 1'b1; bus_wr.key_run = 1'b1;
    bus_ar.key_dir = 1'b1; bus_wr.key_dir = 1'b1;
    model_reset();

    // Reset for three edges, then ticks in IDLE
    idle(15);
    // Start running; then a short glitch that must be ignored
    press(1'b1, 1'b0, 10, 12);
    press(1'b1, 1'b0, 2, 15);
    // Let both counters hit the upper limit and (for ar) bounce back down
    idle(60);
    // Pause, flip direction while paused, resume
    press(1'b1, 1'b0, 10, 20);
    press(1'b0, 1'b1, 10, 20);
    press(1'b1, 1'b0, 10, 25);
    // Simultaneous press in RUN -> CLEAR -> IDLE
    press(1'b1, 1'b1, 10, 15);
    // Back to RUN, then reset landing exactly on the CLEAR cycle
    press(1'b1, 1'b0, 10, 15);
    arm_rst_clear = 1'b1;
    press(1'b1, 1'b1, 10, 20);
    // Reset in the middle of a debounce count; no press may follow
    key_run_v = 1'b0;
    idle(5);
    rst_hold  = 1;
    key_run_v = 1'b1;
    idle(20);
    // Randomized key activity
    for (int i = 0; i < 30; i++) begin
      r = $urandom_range(0, 5);
      case (r)
        0, 1:    press(1'b1, 1'b0, $urandom_range(6, 14), $urandom_range(8, 40));
        2:       press(1'b0, 1'b1, $urandom_range(6, 14), $urandom_range(8, 40));
        3:       press(1'b1, 1'b1, $urandom_range(6, 14), $urandom_range(8, 30));
        4:       press(1'b1, 1'b0, $urandom_range(1, DC - 1), $urandom_range(8, 20));
        default: press(1'b0, 1'b1, $urandom_range(1, DC - 1), $urandom_range(8, 20));
      endcase
    end
    idle(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
